dnn_issue_seq: RTL and testbench

- Upstream/downstream companion to the 4-cycle shared-multiplier DNN core.
- Buffers input sample vectors (x0..x3) in a small FIFO and issues them to the core with a one-cycle in_ready pulse.
- Holds dnn_x stable for the whole pass and paces issues to the core's 4-cycle cadence.
- Captures out0/out1 on the core's output-ready strobe into a tagged result FIFO with valid/ready handshake.

---
 rtl/dnn_issue_seq_if.sv | 39 +++
 rtl/dnn_issue_seq.sv | 179 +++++++++++++++++
 tb/tb_dnn_issue_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_issue_seq_if.sv
// Bundle of the three handshakes around the issue sequencer: sample source,
// DNN core (issue + output strobes) and result consumer.
`timescale 1ns/1ps
interface dnn_issue_seq_if #(
   parameter int TAG_W = 4
);
   logic                    src_valid;
   logic                    src_ready;
   logic signed [6:0]       src_x0, src_x1, src_x2, src_x3;

   logic signed [6:0]       dnn_x0, dnn_x1, dnn_x2, dnn_x3;
   logic                    dnn_in_ready;
   logic signed [20:0]      dnn_out0, dnn_out1;
   logic                    dnn_out0_ready, dnn_out1_ready;

   logic                    res_valid;
   logic                    res_ready;
   logic signed [20:0]      res_out0, res_out1;
   logic [TAG_W-1:0]        res_tag;

   // slave: the sequencer itself; master: everything around it
   modport slave (
      input  src_valid, src_x0, src_x1, src_x2, src_x3,
      output src_ready,
      output dnn_x0, dnn_x1, dnn_x2, dnn_x3, dnn_in_ready,
      input  dnn_out0, dnn_out1, dnn_out0_ready, dnn_out1_ready,
      output res_valid, res_out0, res_out1, res_tag,
      input  res_ready
   );

   modport master (
      output src_valid, src_x0, src_x1, src_x2, src_x3,
      input  src_ready,
      input  dnn_x0, dnn_x1, dnn_x2, dnn_x3, dnn_in_ready,
      output dnn_out0, dnn_out1, dnn_out0_ready, dnn_out1_ready,
      input  res_valid, res_out0, res_out1, res_tag,
      output res_ready
   );
endinterface

// File: rtl/dnn_issue_seq.sv
// Feeds sample vectors to the 4-cycle shared-multiplier DNN core one pass at a
// time and collects its outputs, with their sequence tags, into a result FIFO.
//
//   state  | meaning
//   S_INIT | post-reset quiet window, src_ready low, core strobes ignored
//   S_IDLE | waiting for a sample and a free result credit
//   S_RUN  | pass in progress, phase 1..PASS_CYCLES-1
`timescale 1ns/1ps
module dnn_issue_seq #(
   parameter int IN_DEPTH    = 4,
   parameter int RES_DEPTH   = 2,
   parameter int TAG_W       = 4,
   parameter int PASS_CYCLES = 4,
   parameter int INIT_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   dnn_issue_seq_if.slave  bus,
   output logic            o_busy,
   output logic            o_err_unexp
);
   localparam int IAW = $clog2(IN_DEPTH);
   localparam int RAW = $clog2(RES_DEPTH);
   localparam int ICW = IAW + 1;
   localparam int RCW = RAW + 1;
   localparam int NW  = $clog2(INIT_CYCLES + 1);
   localparam int PW  = $clog2(PASS_CYCLES + 1);
   localparam int SW  = 28;
   localparam int RW  = TAG_W + 42;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN} state_t;

   state_t            r_state;
   logic [NW-1:0]     r_init_cnt;
   logic [PW-1:0]     r_phase;
   logic [SW-1:0]     r_dnn_x;
   logic              r_in_ready;
   logic [TAG_W-1:0]  r_tag_ctr;
   logic [TAG_W-1:0]  r_issue_tag;
   logic [TAG_W-1:0]  r_flight_tag;
   logic              r_in_flight;
   logic              r_err;

   logic [SW-1:0]     r_in_mem [IN_DEPTH];
   logic [IAW-1:0]    r_in_wr, r_in_rd;
   logic [ICW-1:0]    r_in_cnt;

   logic [RW-1:0]     r_res_mem [RES_DEPTH];
   logic [RAW-1:0]    r_res_wr, r_res_rd;
   logic [RCW-1:0]    r_res_cnt;

   logic              w_live, w_src_ready, w_in_full, w_in_push, w_issue;
   logic              w_strobe_any, w_strobe_both, w_capture, w_unexp;
   logic              w_res_full, w_res_pop;
   logic [RCW-1:0]    w_used;
   logic [SW-1:0]     w_src_pack;

   assign w_live      = (r_state != S_INIT);
   assign w_in_full   = (r_in_cnt == ICW'(IN_DEPTH));
   assign w_src_ready = w_live & ~w_in_full;
   assign w_in_push   = bus.src_valid & w_src_ready;
   assign w_src_pack  = {bus.src_x0, bus.src_x1, bus.src_x2, bus.src_x3};

   // Results held plus the pass in flight must leave room for one more result.
   assign w_used  = r_res_cnt + RCW'(r_in_flight);
   assign w_issue = (r_state == S_IDLE) && (r_in_cnt != '0) && (w_used < RCW'(RES_DEPTH));

   assign w_strobe_any  = bus.dnn_out0_ready | bus.dnn_out1_ready;
   assign w_strobe_both = bus.dnn_out0_ready & bus.dnn_out1_ready;
   assign w_capture     = w_live & w_strobe_both & r_in_flight;
   assign w_unexp       = w_live & w_strobe_any & ~(w_strobe_both & r_in_flight);

   assign w_res_full = (r_res_cnt == RCW'(RES_DEPTH));
   assign w_res_pop  = (r_res_cnt != '0) & bus.res_ready;

   assign bus.src_ready    = w_src_ready;
   assign bus.dnn_in_ready = r_in_ready;
   assign bus.dnn_x0       = r_dnn_x[27:21];
   assign bus.dnn_x1       = r_dnn_x[20:14];
   assign bus.dnn_x2       = r_dnn_x[13:7];
   assign bus.dnn_x3       = r_dnn_x[6:0];
   assign bus.res_valid    = (r_res_cnt != '0);
   assign {bus.res_tag, bus.res_out0, bus.res_out1} = r_res_mem[r_res_rd];

   assign o_busy      = r_in_flight | (r_state == S_RUN) | (r_in_cnt != '0) | (r_res_cnt != '0);
   assign o_err_unexp = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_INIT;
         r_init_cnt  <= NW'(INIT_CYCLES - 1);
         r_phase     <= '0;
         r_dnn_x     <= '0;
         r_in_ready  <= 1'b0;
         r_tag_ctr   <= '0;
         r_issue_tag <= '0;
      end else begin
         r_in_ready <= 1'b0;
         unique case (r_state)
            S_INIT: begin
               if (r_init_cnt == '0) r_state <= S_IDLE;
               else r_init_cnt <= r_init_cnt - 1'b1;
            end
            S_IDLE: begin
               if (w_issue) begin
                  r_dnn_x     <= r_in_mem[r_in_rd];
                  r_in_ready  <= 1'b1;
                  r_issue_tag <= r_tag_ctr;
                  r_tag_ctr   <= r_tag_ctr + 1'b1;
                  r_phase     <= PW'(1);
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_phase == PW'(PASS_CYCLES - 1)) begin
                  r_phase <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   // The in-flight tag is taken at the end of the issue cycle so that a strobe
   // for the previous pass arriving in that same cycle still sees the old tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_flight  <= 1'b0;
         r_flight_tag <= '0;
         r_err        <= 1'b0;
      end else begin
         if (r_in_ready) begin
            r_in_flight  <= 1'b1;
            r_flight_tag <= r_issue_tag;
         end else if (w_capture) begin
            r_in_flight <= 1'b0;
         end
         if (w_unexp) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IN_DEPTH; i++) r_in_mem[i] <= '0;
         r_in_wr  <= '0;
         r_in_rd  <= '0;
         r_in_cnt <= '0;
      end else begin
         if (w_in_push) begin
            r_in_mem[r_in_wr] <= w_src_pack;
            r_in_wr           <= r_in_wr + 1'b1;
         end
         if (w_issue) r_in_rd <= r_in_rd + 1'b1;
         r_in_cnt <= r_in_cnt + ICW'(w_in_push) - ICW'(w_issue);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RES_DEPTH; i++) r_res_mem[i] <= '0;
         r_res_wr  <= '0;
         r_res_rd  <= '0;
         r_res_cnt <= '0;
      end else begin
         if (w_capture) begin
            r_res_mem[r_res_wr] <= {r_flight_tag, bus.dnn_out0, bus.dnn_out1};
            r_res_wr            <= r_res_wr + 1'b1;
         end
         if (w_res_pop) r_res_rd <= r_res_rd + 1'b1;
         r_res_cnt <= r_res_cnt + RCW'(w_capture) - RCW'(w_res_pop);
      end
   end

   a_res_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_capture && w_res_full));

endmodule

// File: tb/tb_dnn_issue_seq.sv
// Directed bench for dnn_issue_seq: a small core model answers each issue four
// cycles later and a scoreboard queue holds the results expected at the output.
`timescale 1ns/1ps
module tb_dnn_issue_seq;
   localparam int TAG_W = 4;
   localparam int PASS  = 4;

   logic clk = 1'b0;
   logic rst;
   logic busy, err_unexp;

   dnn_issue_seq_if #(.TAG_W(TAG_W)) bus ();

   dnn_issue_seq #(
      .IN_DEPTH(4), .RES_DEPTH(2), .TAG_W(TAG_W), .PASS_CYCLES(PASS), .INIT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .o_busy(busy), .o_err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int exp_tag = 0;
   int issues = 0;
   int last_issue = 0;
   int core_cnt = 0;
   int core_tag = 0;
   bit chk_gap = 1'b0;
   bit hold_pend = 1'b0;
   bit last_acc = 1'b0;
   logic [27:0] held;
   logic [27:0] sampq [$];
   logic [TAG_W+41:0] expq [$];

   task automatic check(input string name, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   task automatic set_x(input int k);
      bus.src_x0 = 7'(k);
      bus.src_x1 = 7'(-k);
      bus.src_x2 = 7'(2 * k + 1);
      bus.src_x3 = 7'(k - 64);
   endtask

   task automatic strobe(input int a, input int b, input bit r0, input bit r1);
      bus.dnn_out0       = 21'(a);
      bus.dnn_out1       = 21'(b);
      bus.dnn_out0_ready = r0;
      bus.dnn_out1_ready = r1;
   endtask

   // One clock: settle this cycle's handshakes, cross the edge, then update the model.
   task automatic step();
      logic [27:0] accx, s;
      logic [TAG_W+41:0] e;
      bit acc;
      acc  = bus.src_valid && bus.src_ready;
      accx = {bus.src_x0, bus.src_x1, bus.src_x2, bus.src_x3};
      if (bus.res_valid && bus.res_ready) begin
         if (expq.size() == 0) check("res_unexpected", 1, 0);
         else begin
            e = expq.pop_front();
            check("res_tag", bus.res_tag, e[TAG_W+41:42]);
            check("res_out0", bus.res_out0, $signed(e[41:21]));
            check("res_out1", bus.res_out1, $signed(e[20:0]));
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      last_acc = acc;
      if (acc) sampq.push_back(accx);
      bus.dnn_out0_ready = 1'b0;
      bus.dnn_out1_ready = 1'b0;
      if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) strobe(core_tag * 10, -core_tag, 1'b1, 1'b1);
      end
      if (bus.dnn_in_ready) begin
         issues++;
         if (sampq.size() == 0) check("issue_no_sample", 1, 0);
         else begin
            s = sampq.pop_front();
            check("dnn_x_issue", {bus.dnn_x0, bus.dnn_x1, bus.dnn_x2, bus.dnn_x3}, s);
            held = s;
            hold_pend = 1'b1;
         end
         if (chk_gap && issues > 1) check("issue_gap", cyc - last_issue, PASS);
         last_issue = cyc;
         expq.push_back({exp_tag[TAG_W-1:0], 21'(exp_tag * 10), 21'(-exp_tag)});
         core_tag = exp_tag;
         core_cnt = PASS;
         exp_tag  = (exp_tag + 1) % (1 << TAG_W);
      end else if (hold_pend) begin
         check("dnn_x_hold", {bus.dnn_x0, bus.dnn_x1, bus.dnn_x2, bus.dnn_x3}, held);
         hold_pend = 1'b0;
      end
   endtask

   task automatic send(input int n, input int base);
      int budget;
      for (int k = 0; k < n; k++) begin
         set_x(base + k);
         bus.src_valid = 1'b1;
         budget = 0;
         do begin
            step();
            budget++;
         end while (!last_acc && budget < 200);
         if (!last_acc) check("send_timeout", 0, 1);
      end
      bus.src_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expq.size() != 0 || sampq.size() != 0 || busy) && n < 400) begin
         step();
         n++;
      end
      check("drain_done", (expq.size() == 0 && sampq.size() == 0 && !busy), 1);
   endtask

   task automatic clear_model();
      core_cnt  = 0;
      exp_tag   = 0;
      issues    = 0;
      hold_pend = 1'b0;
      sampq.delete();
      expq.delete();
      bus.dnn_out0_ready = 1'b0;
      bus.dnn_out1_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.src_valid = 1'b0;
      clear_model();
      step();
      step();
      rst = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus.src_valid = 1'b0;
      set_x(0);
      strobe(0, 0, 1'b0, 1'b0);
      bus.res_ready = 1'b0;
      step();
      step();

      check("rst_src_ready", bus.src_ready, 0);
      check("rst_in_ready", bus.dnn_in_ready, 0);
      check("rst_dnn_x", {bus.dnn_x0, bus.dnn_x1, bus.dnn_x2, bus.dnn_x3}, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_tag", bus.res_tag, 0);
      check("rst_res_out0", bus.res_out0, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_unexp, 0);

      // First sample, offered throughout the INIT window
      bus.src_x0 = 7'sd3;
      bus.src_x1 = -7'sd2;
      bus.src_x2 = 7'sd5;
      bus.src_x3 = -7'sd64;
      bus.src_valid = 1'b1;
      bus.res_ready = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("init_src_ready", bus.src_ready, 0);
         step();
      end
      check("post_init_src_ready", bus.src_ready, 1);
      step();
      bus.src_valid = 1'b0;
      check("first_push_taken", last_acc, 1);
      check("issue_not_yet", bus.dnn_in_ready, 0);
      step();
      check("first_issue", bus.dnn_in_ready, 1);
      check("first_x0", bus.dnn_x0, 3);
      check("first_x3", bus.dnn_x3, -64);
      check("busy_in_pass", busy, 1);
      drain();

      // Back-to-back issue cadence
      do_reset();
      chk_gap = 1'b1;
      send(4, 1);
      drain();
      check("t2_issues", issues, 4);
      chk_gap = 1'b0;

      // Result credit stall, then fill the sample FIFO
      do_reset();
      bus.res_ready = 1'b0;
      send(5, 10);
      repeat (20) step();
      check("t3_stalled_issues", issues, 2);
      check("t3_res_valid", bus.res_valid, 1);
      send(1, 20);
      check("t4_full_src_ready", bus.src_ready, 0);
      bus.res_ready = 1'b1;
      n = 0;
      while (!bus.dnn_in_ready && n < 50) begin
         check("t4_src_ready_held", bus.src_ready, 0);
         step();
         n++;
      end
      check("t4_resume_issue", bus.dnn_in_ready, 1);
      check("t4_src_ready_after_pop", bus.src_ready, 1);
      drain();
      check("t3_total_issues", issues, 6);

      // Strobe with nothing in flight
      strobe(100, 5, 1'b1, 1'b1);
      step();
      check("t5_err_set", err_unexp, 1);
      check("t5_no_result", bus.res_valid, 0);
      repeat (3) step();
      check("t5_err_sticky", err_unexp, 1);

      // Reset at phase 2, strobe inside the following INIT window
      do_reset();
      check("t6_err_cleared", err_unexp, 0);
      send(1, 30);
      n = 0;
      while (!bus.dnn_in_ready && n < 20) begin
         step();
         n++;
      end
      check("t6_issue", bus.dnn_in_ready, 1);
      step();
      rst = 1'b1;
      clear_model();
      step();
      rst = 1'b0;
      step();
      strobe(77, -77, 1'b1, 1'b1);
      step();
      check("t6_no_result", bus.res_valid, 0);
      check("t6_err", err_unexp, 0);
      check("t6_busy", busy, 0);
      repeat (3) step();
      send(1, 40);
      drain();
      check("t6_issues", issues, 1);
      strobe(9, 9, 1'b1, 1'b0);
      step();
      check("t6_half_strobe_err", err_unexp, 1);

      // Tag wrap over 18 samples
      do_reset();
      send(18, 0);
      drain();
      check("t7_issues", issues, 18);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
